uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, width of each requester byte.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, clk cycles allowed between tx_start and tx_done before abort.
REQ-004 Reset SHALL be rst, asynchronous, active-low; the clock SHALL be clk.
REQ-005 The ports SHALL be:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester transmit request, level
- data_in  in  N_REQ*DATA_BITS  requester i byte at bits [i*DATA_BITS +: DATA_BITS]
- grant  out  N_REQ  one-hot owner of the transmitter, held for the whole transfer
- ack  out  N_REQ  one-cycle pulse to the owner when its byte is sent
- err  out  N_REQ  one-cycle pulse to the owner on timeout abort
- tx_start  out  1  one-cycle start strobe to the UART transmitter
- tx_data  out  DATA_BITS  byte latched for the transmitter, stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse from the transmitter after the stop bit
- busy  out  1  high in every state except IDLE

Function
REQ-006 The FSM SHALL have states IDLE, START, WAIT_DONE and FINISH.
REQ-007 In IDLE with req != 0, the next edge SHALL select the winner, set grant, latch tx_data from the winner's slice, and enter START.
REQ-008 In START, tx_start SHALL be 1 for exactly one cycle, and the next edge SHALL enter WAIT_DONE with the timeout counter cleared.
REQ-009 In WAIT_DONE, tx_done=1 SHALL cause entry to FINISH with ack[owner]=1 during FINISH.
REQ-010 In WAIT_DONE, the counter SHALL increment each cycle; reaching TIMEOUT without tx_done SHALL cause entry to FINISH with err[owner]=1 instead of ack.
REQ-011 FINISH SHALL last one cycle, clear grant, and return to IDLE.
REQ-012 Minimum request-to-tx_start latency SHALL be 2 edges, and back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-013 Arbitration SHALL be round-robin:
- search starts at index last_owner+1 and wraps modulo N_REQ;
- last_owner updates on every grant;
- after reset, last_owner = N_REQ-1, so index 0 has first priority.
REQ-014 A requester still holding req after its ack SHALL be eligible again only behind other pending requesters.
REQ-015 A req deassertion after grant SHALL NOT abort the transfer; ack/err SHALL still be issued.
REQ-016 tx_done SHALL be ignored in IDLE, START and FINISH.
REQ-017 tx_done coinciding with the TIMEOUT cycle SHALL count as success (ack, not err).
REQ-018 grant, ack and err SHALL each be one-hot or zero at all times, and ack and err SHALL never both be set.
REQ-019 tx_data SHALL NOT change while busy=1, regardless of data_in.

Reset
REQ-020 rst low SHALL asynchronously force:
- state IDLE;
- grant, ack, err, tx_start, busy and the counter to 0;
- tx_data to 0;
- last_owner to N_REQ-1.
REQ-021 Reset asserted mid-transfer SHALL drop the transfer silently, with no ack or err.
REQ-022 After reset release, the first grant SHALL occur no earlier than the first rising edge with rst high.

Structure
REQ-023 The state encoding and the default parameter constants SHALL live in shared package uart_pkg.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req, last_owner; outputs one-hot pick and its index), instantiated once.
REQ-025 All registers SHALL be in clk-edge/rst-negedge processes using nonblocking assignment.

Verification
REQ-026 Single request: req=4'b0010, data_in slice1=8'hA5 -> tx_start 2 edges later, tx_data=8'hA5, grant=4'b0010; tx_done pulse -> ack=4'b0010 for 1 cycle, busy low the next cycle.
REQ-027 All four requesting continuously -> grant order 0,1,2,3,0 with one ack each per round.
REQ-028 No tx_done, TIMEOUT=16 -> err[owner] exactly 17 cycles after tx_start, no ack, return to IDLE.
REQ-029 Owner drops req and data_in changes to 8'hFF mid-transfer -> tx_data holds its original value, ack still issued.
REQ-030 rst pulsed low in WAIT_DONE -> all outputs 0 immediately, no ack/err; the next request from index 0 wins first.
REQ-031 Spurious tx_done in IDLE or START -> no state change and no ack.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned DEF_TIMEOUT   = 65535;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        FINISH    = 2'd3
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first active request after last_owner, wrapping.
module rr_picker
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        pos      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            pos = (32'(last_owner) + i) % N_REQ;
            if (!found && req[pos[IDX_W-1:0]]) begin
                pick[pos[IDX_W-1:0]] = 1'b1;
                pick_idx             = pos[IDX_W-1:0];
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters with round-robin ownership,
// a start/done handshake and a per-transfer timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] data_in,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           err,
    output logic                       tx_start,
    output logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_done,
    output logic                       busy
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     last_owner;
    logic [N_REQ-1:0]     pick;
    logic [IDX_W-1:0]     pick_idx;
    logic [DATA_BITS-1:0] sel_data;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .pick       (pick),
        .pick_idx   (pick_idx)
    );

    // Byte of the requester the picker would grant this cycle.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick[i]) begin
                sel_data = data_in[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Transfer FSM; grant and tx_data stay frozen from selection until FINISH ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            ack        <= '0;
            err        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= START;
                        grant      <= pick;
                        last_owner <= pick_idx;
                        tx_data    <= sel_data;
                        tx_start   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    state    <= WAIT_DONE;
                    tx_start <= 1'b0;
                    cnt      <= '0;
                end
                WAIT_DONE: begin
                    cnt <= cnt + CNT_W'(1);
                    // A done on the final counted cycle still wins over the timeout.
                    if (tx_done) begin
                        state <= FINISH;
                        ack   <= grant;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= FINISH;
                        err   <= grant;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    grant <= '0;
                    ack   <= '0;
                    err   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
